mux_scan_sequencer: RTL and testbench

//   Upstream controller for the 31-way, 2-bit channel mux. Drives the mux's 5-bit sel

---
 rtl/mux_scan_sequencer.sv | 72 +++++++
 tb/tb_mux_scan_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a channel-mux select across a wrapping range and streams {channel, data} samples downstream
module mux_scan_sequencer #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2,
  parameter int NUM_CH = 31
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  first_ch,
  input  logic [SEL_W-1:0]  last_ch,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [SEL_W-1:0] max_ch = SEL_W'(NUM_CH - 1);
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD, FIN} state_t;
  state_t           state;
  logic [SEL_W-1:0] last_r;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      last_r    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (first_ch <= max_ch && last_ch <= max_ch) begin
            last_r <= last_ch;
            sel    <= first_ch;
            busy   <= 1'b1;
            state  <= DRIVE;
          end else err <= 1'b1;
        end
        // sel has been stable for a full cycle, so mux_out is settled here
        DRIVE: begin
          out_data  <= mux_out;
          out_ch    <= sel;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          if (sel == last_r) state <= FIN;
          else begin
            sel   <= (sel == max_ch) ? '0 : sel + 1'b1;
            state <= DRIVE;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: randomized scans checked against an arithmetic range/sample model
module tb_mux_scan_sequencer;
  logic       clk = 0, rst_n = 0, start = 0, out_ready = 0;
  logic [4:0] first_ch = 0, last_ch = 0, sel, out_ch;
  logic [1:0] mux_out, out_data;
  logic       out_valid, busy, done, err;
  logic [1:0] lanes [0:30];
  int checks = 0, fails = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_hs = 0, sel_bad = 0;
  logic [6:0] hs_q [$];

  mux_scan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_ch(first_ch), .last_ch(last_ch),
    .sel(sel), .mux_out(mux_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always_comb mux_out = (sel < 5'd31) ? lanes[sel] : 2'b00;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      hs_q.push_back({out_ch, out_data});
      last_hs = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (sel >= 5'd31) sel_bad++;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    checks++; if (sel !== 5'd0) begin fails++; $display("FAIL reset_sel got %0d exp 0", sel); end
    checks++; if ({out_valid, busy, done, err} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {out_valid, busy, done, err}); end
    checks++; if ({out_ch, out_data} !== 7'd0) begin fails++; $display("FAIL reset_out got %0d/%0d exp 0/0", out_ch, out_data); end
  endtask

  // Full scan with static lanes; the model derives channel list and data from the range alone
  task automatic run_scan(input int f, input int l, input bit rnd_ready, input bit noise);
    int n, k;
    bit to;
    logic [6:0] exp_e;
    n = ((l - f + 31) % 31) + 1;
    hs_q.delete();
    done_cnt = 0;
    first_ch = 5'(f);
    last_ch = 5'(l);
    start = 1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    start = 0;
    first_ch = 5'($urandom_range(0, 30));
    last_ch = 5'($urandom_range(0, 30));
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || sel !== 5'(f)) begin fails++; $display("FAIL start_state busy=%b valid=%b sel=%0d exp 1/0/%0d", busy, out_valid, sel, f); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_ch !== 5'(f)) begin fails++; $display("FAIL first_valid valid=%b ch=%0d exp 1/%0d", out_valid, out_ch, f); end
    to = 1;
    for (int i = 0; i < 600; i++) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise && i == 0) begin
        start = 1;
        first_ch = 5'd0;
        last_ch = 5'd30;
      end
      tick();
      start = 0;
      if (done_cnt > 0) begin to = 0; break; end
    end
    out_ready = 0;
    tick();
    tick();
    checks++; if (to) begin fails++; $display("FAIL scan_timeout range %0d..%0d no done", f, l); end
    checks++; if (done_cnt !== 1) begin fails++; $display("FAIL done_count got %0d exp 1", done_cnt); end
    checks++; if (hs_q.size() !== n) begin fails++; $display("FAIL sample_count got %0d exp %0d", hs_q.size(), n); end
    for (k = 0; k < n && k < hs_q.size(); k++) begin
      exp_e = {5'((f + k) % 31), lanes[(f + k) % 31]};
      checks++; if (hs_q[k] !== exp_e) begin fails++; $display("FAIL sample%0d got ch%0d/d%0d exp ch%0d/d%0d", k, hs_q[k][6:2], hs_q[k][1:0], exp_e[6:2], exp_e[1:0]); end
    end
    checks++; if (done_cyc - last_hs !== 2) begin fails++; $display("FAIL done_latency got %0d exp 2", done_cyc - last_hs); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_after got %b exp 0", busy); end
  endtask

  task automatic test_full_range();
    for (int k = 0; k < 31; k++) lanes[k] = 2'(k % 4);
    run_scan(0, 30, 0, 0);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 31; k++) lanes[k] = 2'($urandom_range(0, 3));
    run_scan(29, 1, 0, 0);
    run_scan(29, 1, 1, 0);
  endtask

  task automatic test_random_ranges();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 31; k++) lanes[k] = 2'($urandom_range(0, 3));
      run_scan($urandom_range(0, 30), $urandom_range(0, 30), 1, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] held;
    held = 2'($urandom_range(0, 3));
    lanes[12] = held;
    hs_q.delete();
    done_cnt = 0;
    out_ready = 0;
    first_ch = 5'd12;
    last_ch = 5'd12;
    start = 1;
    tick();
    start = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      lanes[12] = ~lanes[12];
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== held || sel !== 5'd12) begin fails++; $display("FAIL bp_hold%0d valid=%b data=%0d sel=%0d exp 1/%0d/12", i, out_valid, out_data, sel, held); end
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    for (int i = 0; i < 5 && done_cnt == 0; i++) tick();
    tick();
    checks++; if (hs_q.size() !== 1 || done_cnt !== 1) begin fails++; $display("FAIL bp_accept hs=%0d done=%0d exp 1/1", hs_q.size(), done_cnt); end
    checks++; if (hs_q.size() > 0 && hs_q[0] !== {5'd12, held}) begin fails++; $display("FAIL bp_sample got %0d exp %0d", hs_q[0], {5'd12, held}); end
    checks++; if (done_cyc - last_hs !== 2) begin fails++; $display("FAIL bp_done_latency got %0d exp 2", done_cyc - last_hs); end
  endtask

  task automatic test_errors();
    logic [4:0] sel_before;
    sel_before = sel;
    hs_q.delete();
    first_ch = 5'd3;
    last_ch = 5'd31;
    start = 1;
    tick();
    start = 0;
    checks++; if (err !== 1'b1 || busy !== 1'b0 || sel !== sel_before) begin fails++; $display("FAIL err_pulse err=%b busy=%b sel=%0d exp 1/0/%0d", err, busy, sel, sel_before); end
    tick();
    tick();
    checks++; if (err !== 1'b0 || hs_q.size() !== 0 || out_valid !== 1'b0) begin fails++; $display("FAIL err_after err=%b hs=%0d valid=%b exp 0/0/0", err, hs_q.size(), out_valid); end
    for (int k = 0; k < 31; k++) lanes[k] = 2'($urandom_range(0, 3));
    run_scan(3, 5, 1, 1);
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 0;
    first_ch = 5'd7;
    last_ch = 5'd9;
    start = 1;
    tick();
    start = 0;
    tick();
    checks++; if (sel !== 5'd7 || out_valid !== 1'b1) begin fails++; $display("FAIL pre_reset sel=%0d valid=%b exp 7/1", sel, out_valid); end
    done_cnt = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++; if (sel !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_reset sel=%0d valid=%b busy=%b exp 0/0/0", sel, out_valid, busy); end
    out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (done_cnt !== 0 || out_valid !== 1'b0) begin fails++; $display("FAIL post_reset done=%0d valid=%b exp 0/0", done_cnt, out_valid); end
    out_ready = 0;
  endtask

  initial begin
    for (int k = 0; k < 31; k++) lanes[k] = 2'(k % 4);
    test_reset();
    test_full_range();
    test_wrap();
    test_random_ranges();
    test_backpressure();
    test_errors();
    test_reset_mid_hold();
    checks++; if (sel_bad !== 0) begin fails++; $display("FAIL sel_range got %0d cycles with sel>=31 exp 0", sel_bad); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
